// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg -- shared definitions for the decode-stage branch controller.
//   * MIPS branch opcodes and REGIMM (rt field) selectors
//   * FSM state encoding BR_IDLE / BR_STALL / BR_DONE
//   * comparator condition select and a branch decode helper
package branch_ctrl_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef enum logic [1:0] {
    BR_IDLE  = 2'd0,
    BR_STALL = 2'd1,
    BR_DONE  = 2'd2
  } br_state_t;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LEZ = 3'd2,
    CMP_GTZ = 3'd3,
    CMP_LTZ = 3'd4,
    CMP_GEZ = 3'd5
  } cond_t;

  typedef struct packed {
    logic  is_branch;
    logic  use_rt;
    logic  is_link;
    cond_t cond;
  } br_dec_t;

  // Classify an ID instruction; non-branch REGIMM selectors decode as non-branch.
  function automatic br_dec_t decode_branch(input logic [5:0] op, input logic [4:0] sel);
    br_dec_t d;
    d.is_branch = 1'b0;
    d.use_rt    = 1'b0;
    d.is_link   = 1'b0;
    d.cond      = CMP_EQ;
    case (op)
      OP_BEQ:  begin d.is_branch = 1'b1; d.use_rt = 1'b1; d.cond = CMP_EQ; end
      OP_BNE:  begin d.is_branch = 1'b1; d.use_rt = 1'b1; d.cond = CMP_NE; end
      OP_BLEZ: begin d.is_branch = 1'b1; d.cond = CMP_LEZ; end
      OP_BGTZ: begin d.is_branch = 1'b1; d.cond = CMP_GTZ; end
      OP_REGIMM: begin
        case (sel)
          RT_BLTZ:   begin d.is_branch = 1'b1; d.cond = CMP_LTZ; end
          RT_BGEZ:   begin d.is_branch = 1'b1; d.cond = CMP_GEZ; end
          RT_BLTZAL: begin d.is_branch = 1'b1; d.is_link = 1'b1; d.cond = CMP_LTZ; end
          RT_BGEZAL: begin d.is_branch = 1'b1; d.is_link = 1'b1; d.cond = CMP_GEZ; end
          default:   d.is_branch = 1'b0;
        endcase
      end
      default: d.is_branch = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/branch_fwd_sel.sv
// branch_fwd_sel -- operand source select and hazard detect for one branch operand.
// Ports:
//   src                          in 5  : source register number
//   ex_wreg, ex_waddr            in    : EX-stage register write
//   mem_wreg, mem_waddr,
//   mem_memtoreg, mem_alu_out    in    : MEM-stage register write
//   rf_rdata                     in 32 : register file read for src
//   operand                      out 32: selected operand value
//   hazard                       out 1 : producer not yet resolvable ($0 never hazards)
module branch_fwd_sel (
  input  logic [4:0]  src,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_waddr,
  input  logic        mem_wreg,
  input  logic [4:0]  mem_waddr,
  input  logic        mem_memtoreg,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] rf_rdata,
  output logic [31:0] operand,
  output logic        hazard
);

  logic src_nz;
  logic mem_hit;
  logic fwd;

  assign src_nz  = (src != 5'd0);
  assign mem_hit = mem_wreg && (mem_waddr == src) && src_nz;
  // A MEM-stage ALU result is final and can be forwarded; a MEM-stage load is not.
  assign fwd     = mem_hit && !mem_memtoreg;
  assign operand = fwd ? mem_alu_out : rf_rdata;
  assign hazard  = (src_nz && ex_wreg && (ex_waddr == src)) || (mem_hit && mem_memtoreg);

endmodule

// File: rtl/eqcmp.sv
// eqcmp -- branch condition comparator.
// Ports:
//   a, b  in 32 : rs and rt operands (b only matters for EQ/NE)
//   cond  in    : condition select (cond_t)
//   y     out 1 : condition holds
module eqcmp
  import branch_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  cond_t       cond,
  output logic        y
);

  logic a_zero;
  assign a_zero = (a == 32'd0);

  // Signed tests against zero only need the sign bit and a zero detect.
  always_comb begin
    y = 1'b0;
    case (cond)
      CMP_EQ:  y = (a == b);
      CMP_NE:  y = (a != b);
      CMP_LEZ: y = a[31] | a_zero;
      CMP_GTZ: y = ~a[31] & ~a_zero;
      CMP_LTZ: y = a[31];
      CMP_GEZ: y = ~a[31];
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl -- decode-stage branch controller for the 5-stage MIPS pipeline.
// Detects branches in ID, forwards MEM ALU results, stalls IF/ID on unresolved
// producers, evaluates the condition and drives PC redirect / target / link.
// A branch is resolved at most once while ID is held (DONE state).
// Optional feature: define BRANCH_STATS_EN to add statistics counters.
// Ports:
//   clk, rst (sync, active-high)
//   id_valid, id_hold, id_op, id_rs, id_rt, id_pc_plus4, id_imm : ID stage
//   rf_rdata1, rf_rdata2                                       : register file reads
//   ex_wreg/ex_waddr, mem_wreg/mem_waddr/mem_memtoreg/mem_alu_out : writers
//   br_stall, br_flush_e, br_taken, br_target, br_link, br_link_addr : outputs
//   stat_taken, stat_not_taken, stat_stall (BRANCH_STATS_EN only)
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int STAT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_hold,
  input  logic [5:0]  id_op,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [31:0] id_pc_plus4,
  input  logic [31:0] id_imm,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_waddr,
  input  logic        mem_wreg,
  input  logic [4:0]  mem_waddr,
  input  logic        mem_memtoreg,
  input  logic [31:0] mem_alu_out,
  output logic        br_stall,
  output logic        br_flush_e,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        br_link,
  output logic [31:0] br_link_addr
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_not_taken,
  output logic [STAT_W-1:0] stat_stall
`endif
);

  br_dec_t   dec;
  logic      is_br;
  logic [31:0] op_a, op_b;
  logic      hz_rs, hz_rt, hazard;
  logic      cond_true;
  logic      stall, resolve;
  br_state_t state, state_next;

  assign dec   = decode_branch(id_op, id_rt);
  assign is_br = id_valid && dec.is_branch;

  branch_fwd_sel u_fwd_rs (
    .src          (id_rs),
    .ex_wreg      (ex_wreg),
    .ex_waddr     (ex_waddr),
    .mem_wreg     (mem_wreg),
    .mem_waddr    (mem_waddr),
    .mem_memtoreg (mem_memtoreg),
    .mem_alu_out  (mem_alu_out),
    .rf_rdata     (rf_rdata1),
    .operand      (op_a),
    .hazard       (hz_rs)
  );

  branch_fwd_sel u_fwd_rt (
    .src          (id_rt),
    .ex_wreg      (ex_wreg),
    .ex_waddr     (ex_waddr),
    .mem_wreg     (mem_wreg),
    .mem_waddr    (mem_waddr),
    .mem_memtoreg (mem_memtoreg),
    .mem_alu_out  (mem_alu_out),
    .rf_rdata     (rf_rdata2),
    .operand      (op_b),
    .hazard       (hz_rt)
  );

  // rt is only an operand for BEQ/BNE; for REGIMM it is a selector.
  assign hazard = hz_rs || (dec.use_rt && hz_rt);

  eqcmp u_cmp (
    .a    (op_a),
    .b    (op_b),
    .cond (dec.cond),
    .y    (cond_true)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BR_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus stall/resolve strobes; DONE blocks re-resolution while ID is held.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    resolve    = 1'b0;
    if (rst) begin
      state_next = BR_IDLE;
    end else begin
      case (state)
        BR_IDLE, BR_STALL: begin
          if (!is_br) begin
            state_next = BR_IDLE;
          end else if (hazard) begin
            stall      = 1'b1;
            state_next = BR_STALL;
          end else begin
            resolve    = 1'b1;
            state_next = id_hold ? BR_DONE : BR_IDLE;
          end
        end
        BR_DONE: state_next = id_hold ? BR_DONE : BR_IDLE;
        default: state_next = BR_IDLE;
      endcase
    end
  end

  assign br_stall     = stall;
  assign br_flush_e   = stall;
  assign br_taken     = resolve && cond_true;
  assign br_link      = resolve && dec.is_link;
  assign br_target    = id_pc_plus4 + (id_imm << 2);
  assign br_link_addr = id_pc_plus4 + 32'd4;

`ifdef BRANCH_STATS_EN
  // Statistics counters; wrap naturally at 2^STAT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
      stat_stall     <= '0;
    end else begin
      if (resolve && cond_true)  stat_taken     <= stat_taken + STAT_W'(1);
      if (resolve && !cond_true) stat_not_taken <= stat_not_taken + STAT_W'(1);
      if (stall)                 stat_stall     <= stat_stall + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl -- self-checking bench for branch_ctrl: directed scenarios
// followed by randomized stimulus, all compared against a behavioural model.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_hold;
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, ex_waddr, mem_waddr;
  logic [31:0] id_pc_plus4, id_imm, rf_rdata1, rf_rdata2, mem_alu_out;
  logic        ex_wreg, mem_wreg, mem_memtoreg;
  logic        br_stall, br_flush_e, br_taken, br_link;
  logic [31:0] br_target, br_link_addr;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken, stat_not_taken, stat_stall;
`endif

  branch_ctrl #(.STAT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_hold(id_hold),
    .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .id_pc_plus4(id_pc_plus4), .id_imm(id_imm),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_wreg(ex_wreg), .ex_waddr(ex_waddr),
    .mem_wreg(mem_wreg), .mem_waddr(mem_waddr),
    .mem_memtoreg(mem_memtoreg), .mem_alu_out(mem_alu_out),
    .br_stall(br_stall), .br_flush_e(br_flush_e), .br_taken(br_taken),
    .br_target(br_target), .br_link(br_link), .br_link_addr(br_link_addr)
`ifdef BRANCH_STATS_EN
    , .stat_taken(stat_taken), .stat_not_taken(stat_not_taken), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: branch in ID already resolved and ID still held
  bit          m_resolved = 1'b0;
  logic [31:0] m_taken = 32'd0, m_not_taken = 32'd0, m_stalls = 32'd0;

  // last sampled DUT outputs, for scenario-level checks
  logic        s_stall, s_taken, s_link;
  logic [31:0] s_target, s_link_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_operand(input logic [4:0] s, input logic [31:0] rf);
    if (s != 5'd0 && mem_wreg && !mem_memtoreg && mem_waddr == s) return mem_alu_out;
    return rf;
  endfunction

  function automatic bit model_hazard(input logic [4:0] s);
    if (s == 5'd0) return 1'b0;
    return (ex_wreg && ex_waddr == s) || (mem_wreg && mem_memtoreg && mem_waddr == s);
  endfunction

  // Sample DUT at negedge, compare to model, advance model across posedge.
  task automatic step();
    bit br, two, al, hz, cond, res_now, e_stall, e_taken, e_link;
    int sa;
    logic [31:0] a, b;
    @(negedge clk);
    br = 1'b0; two = 1'b0; al = 1'b0; cond = 1'b0;
    a = model_operand(id_rs, rf_rdata1);
    b = model_operand(id_rt, rf_rdata2);
    sa = $signed(a);
    if (id_op == 6'd4) begin br = 1'b1; two = 1'b1; cond = (a == b); end
    else if (id_op == 6'd5) begin br = 1'b1; two = 1'b1; cond = (a != b); end
    else if (id_op == 6'd6) begin br = 1'b1; cond = (sa <= 0); end
    else if (id_op == 6'd7) begin br = 1'b1; cond = (sa > 0); end
    else if (id_op == 6'd1) begin
      if (id_rt == 5'd0 || id_rt == 5'd16) begin br = 1'b1; cond = (sa < 0); end
      if (id_rt == 5'd1 || id_rt == 5'd17) begin br = 1'b1; cond = (sa >= 0); end
      al = br && (id_rt >= 5'd16);
    end
    br = br && id_valid;
    hz = model_hazard(id_rs) || (two && model_hazard(id_rt));
    res_now = 1'b0; e_stall = 1'b0; e_taken = 1'b0; e_link = 1'b0;
    if (!rst && !m_resolved && br) begin
      if (hz) e_stall = 1'b1;
      else begin res_now = 1'b1; e_taken = cond; e_link = al; end
    end
    s_stall = br_stall; s_taken = br_taken; s_link = br_link;
    s_target = br_target; s_link_addr = br_link_addr;
    check_eq("br_stall", {31'd0, br_stall}, {31'd0, e_stall});
    check_eq("br_flush_e", {31'd0, br_flush_e}, {31'd0, e_stall});
    check_eq("br_taken", {31'd0, br_taken}, {31'd0, e_taken});
    check_eq("br_link", {31'd0, br_link}, {31'd0, e_link});
    check_eq("br_target", br_target, id_pc_plus4 + id_imm * 32'd4);
    check_eq("br_link_addr", br_link_addr, id_pc_plus4 + 32'd4);
`ifdef BRANCH_STATS_EN
    check_eq("stat_taken", stat_taken, m_taken);
    check_eq("stat_not_taken", stat_not_taken, m_not_taken);
    check_eq("stat_stall", stat_stall, m_stalls);
`endif
    if (rst) begin
      m_resolved = 1'b0; m_taken = 32'd0; m_not_taken = 32'd0; m_stalls = 32'd0;
    end else begin
      m_resolved = m_resolved ? id_hold : (res_now && id_hold);
      if (res_now && cond)  m_taken++;
      if (res_now && !cond) m_not_taken++;
      if (e_stall)          m_stalls++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    id_valid = 1'b0; id_hold = 1'b0; id_op = 6'd0; id_rs = 5'd0; id_rt = 5'd0;
    id_pc_plus4 = 32'h0; id_imm = 32'h0; rf_rdata1 = 32'h0; rf_rdata2 = 32'h0;
    ex_wreg = 1'b0; ex_waddr = 5'd0; mem_wreg = 1'b0; mem_waddr = 5'd0;
    mem_memtoreg = 1'b0; mem_alu_out = 32'h0;
  endtask

  logic [31:0] vals [6] = '{32'd0, 32'd1, 32'd5, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
  logic [5:0]  ops  [8] = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd1, 6'd0, 6'd35};
  logic [4:0]  sels [6] = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd2, 5'd3};
  int stall_cnt;

  initial begin
    quiet();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_eq("reset_stall", {31'd0, s_stall}, 32'd0);

    // BEQ equal operands, no hazard
    id_valid = 1'b1; id_op = 6'd4; id_rs = 5'd3; id_rt = 5'd4;
    rf_rdata1 = 32'd5; rf_rdata2 = 32'd5; id_pc_plus4 = 32'h100; id_imm = 32'h10;
    step();
    check_eq("beq_taken", {31'd0, s_taken}, 32'd1);
    check_eq("beq_target", s_target, 32'h140);
    check_eq("beq_stall", {31'd0, s_stall}, 32'd0);

    // BNE with load in EX: two stall cycles, then not taken
    quiet(); id_valid = 1'b1; id_op = 6'd5; id_rs = 5'd2; id_rt = 5'd4;
    rf_rdata1 = 32'd3; rf_rdata2 = 32'd9;
    stall_cnt = 0;
    ex_wreg = 1'b1; ex_waddr = 5'd2;
    step(); stall_cnt += int'(s_stall);
    ex_wreg = 1'b0; mem_wreg = 1'b1; mem_memtoreg = 1'b1; mem_waddr = 5'd2;
    step(); stall_cnt += int'(s_stall);
    mem_wreg = 1'b0; mem_memtoreg = 1'b0; rf_rdata1 = 32'd9;
    step(); stall_cnt += int'(s_stall);
    check_eq("bne_load_stalls", stall_cnt, 32'd2);
    check_eq("bne_taken", {31'd0, s_taken}, 32'd0);

    // BGTZ with MEM ALU forward of a negative value
    quiet(); id_valid = 1'b1; id_op = 6'd7; id_rs = 5'd5; rf_rdata1 = 32'd7;
    mem_wreg = 1'b1; mem_waddr = 5'd5; mem_alu_out = 32'hFFFFFFFF;
    step();
    check_eq("bgtz_fwd_taken", {31'd0, s_taken}, 32'd0);
    check_eq("bgtz_fwd_stall", {31'd0, s_stall}, 32'd0);

    // BGEZAL on $0, then an unused REGIMM selector
    quiet(); id_valid = 1'b1; id_op = 6'd1; id_rt = 5'd17; id_pc_plus4 = 32'h200;
    step();
    check_eq("bgezal_taken", {31'd0, s_taken}, 32'd1);
    check_eq("bgezal_link", {31'd0, s_link}, 32'd1);
    check_eq("bgezal_link_addr", s_link_addr, 32'h204);
    id_rt = 5'd2;
    step();
    check_eq("regimm2_taken", {31'd0, s_taken}, 32'd0);
    check_eq("regimm2_link", {31'd0, s_link}, 32'd0);

    // BEQ resolved once under a 3-cycle hold
    quiet(); id_valid = 1'b1; id_op = 6'd4; id_rs = 5'd3; id_rt = 5'd4; id_hold = 1'b1;
    step(); check_eq("hold_taken_c0", {31'd0, s_taken}, 32'd1);
    step(); check_eq("hold_taken_c1", {31'd0, s_taken}, 32'd0);
    step(); check_eq("hold_taken_c2", {31'd0, s_taken}, 32'd0);
    id_hold = 1'b0; id_valid = 1'b0;
    step();

    // reset in the middle of a stall
    quiet(); id_valid = 1'b1; id_op = 6'd4; id_rs = 5'd6; ex_wreg = 1'b1; ex_waddr = 5'd6;
    step(); check_eq("pre_rst_stall", {31'd0, s_stall}, 32'd1);
    rst = 1'b1;
    step(); check_eq("rst_stall", {31'd0, s_stall}, 32'd0);
    rst = 1'b0; ex_wreg = 1'b0;
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(99) < 2);
      id_valid     = ($urandom_range(9) != 0);
      id_hold      = ($urandom_range(9) < 4);
      id_op        = ops[$urandom_range(7)];
      id_rs        = 5'($urandom_range(3));
      id_rt        = (id_op == 6'd1) ? sels[$urandom_range(5)] : 5'($urandom_range(3));
      id_pc_plus4  = $urandom;
      id_imm       = $urandom;
      rf_rdata1    = vals[$urandom_range(5)];
      rf_rdata2    = vals[$urandom_range(5)];
      ex_wreg      = ($urandom_range(3) == 0);
      ex_waddr     = 5'($urandom_range(3));
      mem_wreg     = ($urandom_range(1) == 0);
      mem_waddr    = 5'($urandom_range(3));
      mem_memtoreg = ($urandom_range(2) == 0);
      mem_alu_out  = vals[$urandom_range(5)];
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Decode-stage branch controller for the 5-stage MIPS pipeline. It detects conditional branches in ID, selects each branch operand from the register file or the MEM-stage ALU result, and stalls ID/IF while a producer is still unresolved. Once operands are ready it evaluates the condition with the existing `eqcmp` comparator and drives the PC redirect, target and link address. It also guarantees that each branch instance is resolved exactly once while ID is held by other stall sources.

## Interface
Parameters:
- `STAT_W`, 32, width of statistics counters (only used with `BRANCH_STATS_EN`)

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a valid instruction.
- `id_hold` in 1: ID is held this cycle by a source other than this block.
- `id_op` in 6: opcode field.
- `id_rs`, `id_rt` in 5 each: source register fields. `id_rt` is also the REGIMM selector.
- `id_pc_plus4` in 32: PC+4 of the ID instruction.
- `id_imm` in 32: sign-extended immediate.
- `rf_rdata1`, `rf_rdata2` in 32: register file reads for rs and rt.
- `ex_wreg` in 1, `ex_waddr` in 5: EX-stage register write.
- `mem_wreg` in 1, `mem_waddr` in 5, `mem_memtoreg` in 1, `mem_alu_out` in 32: MEM-stage write info.
- `br_stall` out 1: stall IF and ID.
- `br_flush_e` out 1: insert a bubble into EX.
- `br_taken` out 1: redirect the PC this cycle.
- `br_target` out 32: branch target.
- `br_link` out 1: instruction is BLTZAL or BGEZAL.
- `br_link_addr` out 32: value written to $31.
- `stat_taken`, `stat_not_taken`, `stat_stall` out `STAT_W` each: present only with `BRANCH_STATS_EN`.

## Operation
- **Branch decode.** A branch is one of: BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, or REGIMM 000001 with `id_rt` equal to BLTZ 00000, BGEZ 00001, BLTZAL 10000 or BGEZAL 10001. Any other REGIMM selector is a non-branch.
- **Operands used.** BEQ and BNE use rs and rt. All other branches use rs only.
- **Hazard.** Raised for a used operand `s` with `s != 0` when either:
  - `ex_wreg && ex_waddr == s`, or
  - `mem_wreg && mem_memtoreg && mem_waddr == s`.
- **Forwarding.** If `mem_wreg && !mem_memtoreg && mem_waddr == s && s != 0`, the operand is `mem_alu_out`. Otherwise it is `rf_rdata`.
- **Target and link.** `br_target = id_pc_plus4 + (id_imm << 2)`, mod 2^32. `br_link_addr = id_pc_plus4 + 4`. `br_link` is asserted for AL branches whether or not the branch is taken. There is a delay slot, so IF is never flushed.
- **FSM states:** IDLE, STALL, DONE.
  - **IDLE:**
    - Valid branch with hazard → STALL.
    - Valid branch without hazard → resolve this cycle; next state is DONE if `id_hold`, else IDLE.
  - **STALL:**
    - Hazard still present → stay in STALL.
    - Hazard cleared → resolve this cycle; next state is DONE if `id_hold`, else IDLE.
  - **DONE:**
    - `id_hold` low → IDLE.
    - No resolution happens in DONE.
- **Resolve cycle.** `br_taken` is the comparator result. In every other cycle `br_taken` is 0.
- **Stall outputs.** `br_stall = br_flush_e = 1` in every cycle in which a hazard exists and the FSM is not in DONE. This includes the IDLE cycle that enters STALL.
- **Invalid or non-branch instruction.** `id_valid` low or a non-branch opcode in IDLE or STALL means no stall and no taken; the FSM goes to IDLE.

## Timing
- Resolution is combinational in the resolve cycle, so the PC redirect takes effect at the next edge.
- Stall lengths:
  - Load in EX: 2 stall cycles.
  - ALU producer in EX: 1 stall cycle.
  - Load in MEM: 1 stall cycle.
- Reset values:
  - FSM = IDLE.
  - `br_stall`, `br_flush_e`, `br_taken`, `br_link` = 0.
  - `br_target` and `br_link_addr` follow their inputs combinationally.
  - All stat counters = 0.
- Reset asserted mid-stall or in DONE forces IDLE at the next edge. Outputs are 0 while `rst` is high.
- `id_hold` asserted together with a hazard: the hazard path governs; the branch resolves on the first hazard-free cycle.

## Configuration
- **`BRANCH_STATS_EN` defined:**
  - `stat_taken` / `stat_not_taken` increment once per resolve cycle.
  - `stat_stall` increments once per `br_stall` cycle.
  - All three wrap at 2^`STAT_W`.
- **`BRANCH_STATS_EN` undefined:** the stat ports and counters are absent; all other behaviour is identical.

## Structure
- **Shared package / `defines.vh`:** branch opcode and REGIMM selector constants, and the FSM state encoding `BR_IDLE` / `BR_STALL` / `BR_DONE`.
- **Sub-module `branch_fwd_sel`** (instantiated twice, once per operand):
  - Inputs: source register, the EX/MEM write info and the register file data.
  - Outputs: `operand` and `hazard`.
- **Condition evaluation:** one `eqcmp` instance.

## Test plan
- **BEQ, equal operands.** rs=$3=5, rt=$4=5, no hazard, `id_pc_plus4`=0x100, `id_imm`=0x10 → same cycle `br_taken`=1, `br_target`=0x140, `br_stall`=0.
- **BNE, load in EX.** rs=$2, EX load writes $2 → `br_stall`=1 for 2 cycles. Then the value is read from the register file (equal to rt) → `br_taken`=0, FSM back in IDLE.
- **BGTZ, MEM forward.** MEM ALU writes $5=0xFFFFFFFF, register file holds stale 7 → operand forwarded, `br_taken`=0 (negative), no stall.
- **BGEZAL.** rs=0, `id_pc_plus4`=0x200 → `br_taken`=1, `br_link`=1, `br_link_addr`=0x204. REGIMM with selector 00010 → `br_taken`=0, `br_link`=0.
- **Resolve under hold.** BEQ taken with `id_hold` high for 3 cycles → `br_taken`=1 only in the first cycle, FSM in DONE for the remaining hold cycles, IDLE after release. With stats: `stat_taken`=1.
- **Reset mid-stall.** `rst` pulsed during STALL → next cycle FSM=IDLE, all outputs 0, stats 0.
